ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Shares one single-read-port / single-write-port RAM instance between NUM_CLIENTS requesters, with independent round-robin arbitration for reads and for writes.
- Registers the winning request onto the RAM ports and tracks each in-flight read with a client-ID pipeline. Read data returns with a one-hot valid to the issuing client.
- Sits between the compute-side buffer users and the RAM primitive.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..16).
- DATA_WIDTH, 10, RAM word width.
- ADDR_WIDTH, 12, RAM address width.
- RAM_RD_LATENCY, 2, cycles from RAM s_read_req to valid s_read_data (RAM adds address and data registers).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cl_rd_req  in  NUM_CLIENTS  per-client read request; client holds it until granted.
- cl_rd_addr  in  NUM_CLIENTS*ADDR_WIDTH  flattened read addresses; client i uses slice i.
- cl_rd_gnt  out  NUM_CLIENTS  one-hot read grant, combinational, same cycle as acceptance.
- cl_rd_data  out  DATA_WIDTH  read data, broadcast to all clients.
- cl_rd_valid  out  NUM_CLIENTS  one-hot; marks cl_rd_data as belonging to client i.
- cl_wr_req  in  NUM_CLIENTS  per-client write request.
- cl_wr_addr  in  NUM_CLIENTS*ADDR_WIDTH  flattened write addresses.
- cl_wr_data  in  NUM_CLIENTS*DATA_WIDTH  flattened write data.
- cl_wr_gnt  out  NUM_CLIENTS  one-hot write grant, combinational.
- ram_read_req  out  1  to RAM s_read_req.
- ram_read_addr  out  ADDR_WIDTH  to RAM s_read_addr.
- ram_read_data  in  DATA_WIDTH  from RAM s_read_data.
- ram_write_req  out  1  to RAM s_write_req.
- ram_write_addr  out  ADDR_WIDTH  to RAM s_write_addr.
- ram_write_data  out  DATA_WIDTH  to RAM s_write_data.

Behaviour:
- Reset values (asynchronous): ram_read_req, ram_write_req, ram_*_addr, ram_write_data = 0; both round-robin pointers = 0; ID pipeline valids = 0; cl_rd_valid = 0.
- cl_rd_data is driven directly by ram_read_data.
- Arbitration, read and write independent:
  - One grant per direction per cycle.
  - Search starts at the pointer index and wraps modulo NUM_CLIENTS.
  - On a grant to client k, the pointer moves to (k+1) mod NUM_CLIENTS.
  - With no requests, the pointer holds and the grant is 0.
  - The grant is a pure function of the current requests and the pointer. No grant occurs during reset.
- Issue: the grant at cycle t registers the request, address and data onto the RAM ports at t+1. ram_*_req is high for exactly one cycle per grant.
- Back-to-back grants are allowed, giving a throughput of one read plus one write per cycle.
- Read return:
  - The granted client ID plus a valid bit enter a pipeline of depth 1+RAM_RD_LATENCY.
  - cl_rd_valid[k] is high at t+3 (default parameters), aligned with ram_read_data.
  - Responses come back in grant order.
- Write completion: the RAM commits mem at the t+2 edge. No acknowledge beyond cl_wr_gnt.
- Same-cycle read and write to one address: the read returns old data. A read granted at least 1 cycle after the write returns new data.
- Requests dropped before grant are legal; no state changes.
- Reset mid-operation clears in-flight IDs. No cl_rd_valid is produced for reads issued before reset.
- The RAM reset is synchronous, so the bench holds reset for at least 2 clk edges.

Decomposition:
- Shared package holds:
  - function clog2;
  - localparam CLIENT_ID_W = max(1, clog2(NUM_CLIENTS));
  - localparam RD_PIPE_DEPTH = 1 + RAM_RD_LATENCY.
- Sub-module rr_arbiter (parameter N) contains the request vector, pointer register and one-hot grant. It is instantiated twice, once for reads and once for writes.
- The ID pipeline and issue registers stay in the top module.

Test Plan:
- Single read: client 2 requests addr 0x05A after the RAM was preloaded with 0x155 at 0x05A. Required: cl_rd_gnt = 0100 at t, ram_read_req at t+1, cl_rd_valid = 0100 with data 0x155 at t+3.
- Round-robin: all 4 clients hold rd_req from the pointer = 0 state. Required: grants 0,1,2,3,0 on consecutive cycles; valids follow in the same order 3 cycles later.
- Fairness after skip: only clients 1 and 3 request, pointer = 2. Required: grant 3, then 1, then 3.
- Write then read: client 0 writes 0x3FF to 0x010 at cycle t.
  - Client 1 reads 0x010 at t: returns old data.
  - Client 1 reads 0x010 at t+1: returns 0x3FF.
- Concurrent read and write: client 0 reads and client 3 writes every cycle for 8 cycles. Required: both ram_*_req high every cycle; 8 valids to client 0.
- Reset mid-flight: assert reset 1 cycle after a read grant. Required: no cl_rd_valid afterwards, pointers = 0, ram_read_req = 0 immediately.

Source files
------------

// File: rtl/ram_access_arbiter_pkg.sv
// Shared helpers for the RAM access arbiter: sizing functions for client IDs
// and the read-return pipeline.
package ram_access_arbiter_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Width of a client index; never below one bit.
  function automatic int client_id_w(input int num_clients);
    return (clog2(num_clients) > 1) ? clog2(num_clients) : 1;
  endfunction

  // Read-return depth: one issue register plus the RAM's own latency.
  function automatic int rd_pipe_depth(input int ram_rd_latency);
    return 1 + ram_rd_latency;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant from the request vector and
// a rotating priority pointer that moves just past each winner.
module rr_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = client_id_w(N);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win_idx_s;
  logic [PW:0]   cand_s;
  logic          win_found_s;

  // Search from the pointer upward, wrapping modulo N, for the first requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_r} + (PW+1)'(i);
      if (cand_s >= (PW+1)'(N)) begin
        cand_s = cand_s - (PW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[PW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[PW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot grant, suppressed while reset is held.
  always_comb begin
    gnt = '0;
    if (win_found_s && !reset) begin
      gnt[win_idx_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Pointer advances to the slot after the winner; holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (win_found_s) begin
      ptr_r <= (win_idx_s == PW'(N-1)) ? '0 : win_idx_s + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one 1R/1W RAM among NUM_CLIENTS requesters: independent round-robin
// read/write arbitration, registered RAM ports, in-order read-return tagging.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int DATA_WIDTH     = 10,
  parameter int ADDR_WIDTH     = 12,
  parameter int RAM_RD_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            cl_rd_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_rd_addr,
  output logic [NUM_CLIENTS-1:0]            cl_rd_gnt,
  output logic [DATA_WIDTH-1:0]             cl_rd_data,
  output logic [NUM_CLIENTS-1:0]            cl_rd_valid,
  input  logic [NUM_CLIENTS-1:0]            cl_wr_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_wr_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wr_data,
  output logic [NUM_CLIENTS-1:0]            cl_wr_gnt,
  output logic                              ram_read_req,
  output logic [ADDR_WIDTH-1:0]             ram_read_addr,
  input  logic [DATA_WIDTH-1:0]             ram_read_data,
  output logic                              ram_write_req,
  output logic [ADDR_WIDTH-1:0]             ram_write_addr,
  output logic [DATA_WIDTH-1:0]             ram_write_data
);

  localparam int CLIENT_ID_W   = client_id_w(NUM_CLIENTS);
  localparam int RD_PIPE_DEPTH = rd_pipe_depth(RAM_RD_LATENCY);
  localparam int ID_STAGES     = RD_PIPE_DEPTH - 1;

  logic                   rd_any_s;
  logic                   wr_any_s;
  logic [CLIENT_ID_W-1:0] rd_id_s;
  logic [ADDR_WIDTH-1:0]  rd_addr_s;
  logic [ADDR_WIDTH-1:0]  wr_addr_s;
  logic [DATA_WIDTH-1:0]  wr_data_s;
  logic [CLIENT_ID_W-1:0] id_pipe_r [ID_STAGES];
  logic [ID_STAGES-1:0]   vld_pipe_r;
  logic [NUM_CLIENTS-1:0] rd_ret_onehot_s;

  rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req   (cl_rd_req),
    .gnt   (cl_rd_gnt)
  );

  rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (cl_wr_req),
    .gnt   (cl_wr_gnt)
  );

  assign rd_any_s   = |cl_rd_gnt;
  assign wr_any_s   = |cl_wr_gnt;
  assign cl_rd_data = ram_read_data;

  // Select the granted client's read address and ID from the one-hot grant.
  always_comb begin
    rd_id_s   = '0;
    rd_addr_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cl_rd_gnt[i]) begin
        rd_id_s   = CLIENT_ID_W'(i);
        rd_addr_s = cl_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        rd_id_s   = rd_id_s;
        rd_addr_s = rd_addr_s;
      end
    end
  end

  // Select the granted client's write address and data.
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cl_wr_gnt[i]) begin
        wr_addr_s = cl_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_s = cl_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        wr_addr_s = wr_addr_s;
        wr_data_s = wr_data_s;
      end
    end
  end

  // Issue registers: request strobes last one cycle; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_read_req   <= 1'b0;
      ram_read_addr  <= '0;
      ram_write_req  <= 1'b0;
      ram_write_addr <= '0;
      ram_write_data <= '0;
    end else begin
      ram_read_req  <= rd_any_s;
      ram_write_req <= wr_any_s;
      if (rd_any_s) begin
        ram_read_addr <= rd_addr_s;
      end else begin
        ram_read_addr <= ram_read_addr;
      end
      if (wr_any_s) begin
        ram_write_addr <= wr_addr_s;
        ram_write_data <= wr_data_s;
      end else begin
        ram_write_addr <= ram_write_addr;
        ram_write_data <= ram_write_data;
      end
    end
  end

  // Decode the oldest in-flight read tag into the one-hot return valid.
  always_comb begin
    rd_ret_onehot_s = '0;
    if (vld_pipe_r[ID_STAGES-1]) begin
      rd_ret_onehot_s[id_pipe_r[ID_STAGES-1]] = 1'b1;
    end else begin
      rd_ret_onehot_s = '0;
    end
  end

  // Client-ID pipeline; the final register stage lines cl_rd_valid up with RAM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_r  <= '0;
      cl_rd_valid <= '0;
      for (int j = 0; j < ID_STAGES; j++) begin
        id_pipe_r[j] <= '0;
      end
    end else begin
      vld_pipe_r[0] <= rd_any_s;
      id_pipe_r[0]  <= rd_id_s;
      for (int j = 1; j < ID_STAGES; j++) begin
        vld_pipe_r[j] <= vld_pipe_r[j-1];
        id_pipe_r[j]  <= id_pipe_r[j-1];
      end
      cl_rd_valid <= rd_ret_onehot_s;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural RAM and a
// scoreboard of expected read returns (client, data, due cycle).
module tb_ram_access_arbiter;

  localparam int NC = 4;
  localparam int DW = 10;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     cl_rd_req;
  logic [NC*AW-1:0]  cl_rd_addr;
  logic [NC-1:0]     cl_rd_gnt;
  logic [DW-1:0]     cl_rd_data;
  logic [NC-1:0]     cl_rd_valid;
  logic [NC-1:0]     cl_wr_req;
  logic [NC*AW-1:0]  cl_wr_addr;
  logic [NC*DW-1:0]  cl_wr_data;
  logic [NC-1:0]     cl_wr_gnt;
  logic              ram_read_req;
  logic [AW-1:0]     ram_read_addr;
  logic [DW-1:0]     ram_read_data;
  logic              ram_write_req;
  logic [AW-1:0]     ram_write_addr;
  logic [DW-1:0]     ram_write_data;

  always #5 clk = ~clk;

  ram_access_arbiter #(
    .NUM_CLIENTS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cl_rd_req(cl_rd_req), .cl_rd_addr(cl_rd_addr), .cl_rd_gnt(cl_rd_gnt),
    .cl_rd_data(cl_rd_data), .cl_rd_valid(cl_rd_valid),
    .cl_wr_req(cl_wr_req), .cl_wr_addr(cl_wr_addr), .cl_wr_data(cl_wr_data),
    .cl_wr_gnt(cl_wr_gnt),
    .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data),
    .ram_write_req(ram_write_req), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data)
  );

  // Behavioural RAM: array sampled at the request edge, plus an output register.
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] rd_d1, rd_d2;
  always @(posedge clk) begin
    if (reset) begin
      rd_d1 <= '0;
      rd_d2 <= '0;
    end else begin
      if (ram_read_req) rd_d1 <= mem[ram_read_addr];
      rd_d2 <= rd_d1;
      if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
    end
  end
  assign ram_read_data = rd_d2;

  typedef struct {
    logic [NC-1:0] who;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cycle = 0;
  int   v0_cnt = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_ra, prev_wa, mon_a;
  logic [DW-1:0] prev_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] preload(input int a);
    return DW'(a * 13 + 7);
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: issue-port timing, read-return scoreboard, shadow memory update.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      check("ram_rd_req", {31'd0, ram_read_req}, {31'd0, prev_rd});
      if (prev_rd) check("ram_rd_addr", ram_read_addr, prev_ra);
      check("ram_wr_req", {31'd0, ram_write_req}, {31'd0, prev_wr});
      if (prev_wr) begin
        check("ram_wr_addr", ram_write_addr, prev_wa);
        check("ram_wr_data", ram_write_data, prev_wd);
      end
      if (cl_rd_valid == 4'b0001) v0_cnt++;
      if (cl_rd_valid !== '0) begin
        if (sb_q.size() == 0) begin
          check("unexp_valid", cl_rd_valid, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rd_valid", cl_rd_valid, mon_e.who);
          check("rd_data", cl_rd_data, mon_e.data);
          check("rd_latency", cycle, mon_e.due);
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
        mon_e = sb_q.pop_front();
        check("rd_missing", cl_rd_valid, mon_e.who);
      end
      prev_rd = |cl_rd_gnt;
      for (int i = 0; i < NC; i++) begin
        if (cl_rd_gnt[i]) begin
          mon_a   = cl_rd_addr[i*AW +: AW];
          prev_ra = mon_a;
          sb_q.push_back('{who: cl_rd_gnt, data: shadow[mon_a], due: cycle + 3});
        end
      end
      prev_wr = |cl_wr_gnt;
      for (int i = 0; i < NC; i++) begin
        if (cl_wr_gnt[i]) begin
          prev_wa = cl_wr_addr[i*AW +: AW];
          prev_wd = cl_wr_data[i*DW +: DW];
          shadow[prev_wa] = prev_wd;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [NC-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NC-1:0] skip_exp [3] = '{4'b1000, 4'b0010, 4'b1000};

  initial begin
    reset = 1'b1;
    cl_rd_req = '0; cl_rd_addr = '0;
    cl_wr_req = '0; cl_wr_addr = '0; cl_wr_data = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = preload(a);
      shadow[a] = preload(a);
    end
    mem[12'h05A]    = 10'h155;
    shadow[12'h05A] = 10'h155;

    // Reset state, with requests present that must not be granted.
    cl_rd_req = 4'b1111;
    cl_wr_req = 4'b1111;
    sample();
    check("rst_rd_gnt", cl_rd_gnt, 32'd0);
    check("rst_wr_gnt", cl_wr_gnt, 32'd0);
    check("rst_ram_rd_req", {31'd0, ram_read_req}, 32'd0);
    check("rst_ram_wr_req", {31'd0, ram_write_req}, 32'd0);
    check("rst_ram_rd_addr", ram_read_addr, 32'd0);
    check("rst_ram_wr_data", ram_write_data, 32'd0);
    check("rst_rd_valid", cl_rd_valid, 32'd0);
    cl_rd_req = '0;
    cl_wr_req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single read by client 2.
    cl_rd_req = 4'b0100;
    cl_rd_addr[2*AW +: AW] = 12'h05A;
    sample();
    check("single_gnt", cl_rd_gnt, 32'h4);
    tick();
    cl_rd_req = '0;
    sample();
    check("single_ram_req", {31'd0, ram_read_req}, 32'd1);
    check("single_ram_addr", ram_read_addr, 32'h05A);
    tick(); tick();
    sample();
    check("single_valid", cl_rd_valid, 32'h4);
    check("single_data", cl_rd_data, 32'h155);
    repeat (3) tick();

    // Reset to bring the pointers back to zero, then round-robin over all clients.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NC; i++) cl_rd_addr[i*AW +: AW] = AW'(12'h100 + i);
    cl_rd_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sample();
      check("rr_gnt", cl_rd_gnt, rr_exp[k]);
      tick();
    end
    cl_rd_req = '0;
    repeat (4) tick();

    // Move the pointer to 2, then only clients 1 and 3 request.
    cl_rd_req = 4'b0010;
    sample();
    check("skip_setup_gnt", cl_rd_gnt, 32'h2);
    tick();
    cl_rd_req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("skip_gnt", cl_rd_gnt, skip_exp[k]);
      tick();
    end
    cl_rd_req = '0;
    repeat (4) tick();

    // Write then read of one address: same-cycle read sees old data.
    cl_wr_req = 4'b0001;
    cl_wr_addr[0 +: AW] = 12'h010;
    cl_wr_data[0 +: DW] = 10'h3FF;
    cl_rd_req = 4'b0010;
    cl_rd_addr[1*AW +: AW] = 12'h010;
    sample();
    check("wr_gnt", cl_wr_gnt, 32'h1);
    check("raw_rd_gnt0", cl_rd_gnt, 32'h2);
    tick();
    cl_wr_req = '0;
    sample();
    check("raw_rd_gnt1", cl_rd_gnt, 32'h2);
    tick();
    cl_rd_req = '0;
    tick();
    sample();
    check("raw_old_valid", cl_rd_valid, 32'h2);
    check("raw_old_data", cl_rd_data, preload(16));
    tick();
    sample();
    check("raw_new_data", cl_rd_data, 32'h3FF);
    repeat (3) tick();

    // Concurrent traffic: client 0 reads, client 3 writes, every cycle.
    v0_cnt = 0;
    cl_rd_req = 4'b0001;
    cl_wr_req = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      cl_rd_addr[0 +: AW]    = AW'(12'h2FF + k);
      cl_wr_addr[3*AW +: AW] = AW'(12'h300 + k);
      cl_wr_data[3*DW +: DW] = DW'(k * 37 + 1);
      sample();
      check("conc_rd_gnt", cl_rd_gnt, 32'h1);
      check("conc_wr_gnt", cl_wr_gnt, 32'h8);
      if (k > 0) begin
        check("conc_ram_rd", {31'd0, ram_read_req}, 32'd1);
        check("conc_ram_wr", {31'd0, ram_write_req}, 32'd1);
      end
      tick();
    end
    cl_rd_req = '0;
    cl_wr_req = '0;
    sample();
    check("conc_ram_rd_last", {31'd0, ram_read_req}, 32'd1);
    check("conc_ram_wr_last", {31'd0, ram_write_req}, 32'd1);
    repeat (5) tick();
    check("conc_valid_count", v0_cnt, 32'd8);

    // Reset one cycle after a read grant.
    cl_rd_req = 4'b0100;
    cl_rd_addr[2*AW +: AW] = 12'h05A;
    sample();
    check("mid_gnt", cl_rd_gnt, 32'h4);
    tick();
    cl_rd_req = '0;
    reset = 1'b1;
    #1;
    check("mid_ram_rd_req", {31'd0, ram_read_req}, 32'd0);
    check("mid_rd_valid", cl_rd_valid, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      check("post_rst_valid", cl_rd_valid, 32'd0);
      tick();
    end
    cl_rd_req = 4'b1111;
    cl_wr_req = 4'b1111;
    sample();
    check("post_rst_rd_ptr", cl_rd_gnt, 32'h1);
    check("post_rst_wr_ptr", cl_wr_gnt, 32'h1);
    tick();
    cl_rd_req = '0;
    cl_wr_req = '0;

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) tick();
    check("sb_drain", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
